// File: rtl/bp_update_scheduler.sv
// Write-port scheduler for the branch target / pattern table. It runs the init and flush
// sweeps and drains a small in-order FIFO of resolved predictor updates.
module bp_update_scheduler #(
   parameter int IDX_W = 6,
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                upd_valid,
   output logic                upd_ready,
   input  logic [31:0]         upd_pc,
   input  logic [31:0]         upd_target,
   input  logic [1:0]          upd_state,
   input  logic                hazard_stall,
   input  logic                flush_req,
   output logic                flush_done,
   output logic                bt_we,
   output logic [IDX_W-1:0]    bt_idx,
   output logic [29-IDX_W:0]   bt_tag,
   output logic [31:0]         bt_target,
   output logic [1:0]          bt_state,
   output logic                bt_valid,
   output logic                busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic [1:0] {S_INIT, S_RUN, S_FLUSH} state_e;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [TAG_W-1:0] tag;
      logic [31:0]      target;
      logic [1:0]       state;
   } entry_t;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic               flush_q, flush_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               upd_ready_q, upd_ready_d;
   logic               flush_done_q, flush_done_d;
   logic               busy_q, busy_d;
   logic               we_q, we_d;
   entry_t             wr_q, wr_d;
   logic               valid_q, valid_d;
   entry_t             mem_q [DEPTH];
   entry_t             head;
   logic               sweep_wr, last, push, pop;
   logic               unused_pc;

   assign unused_pc = ^upd_pc[1:0];
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      flush_d      = flush_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      flush_done_d = 1'b0;
      we_d         = 1'b0;
      wr_d         = wr_q;
      valid_d      = valid_q;

      // A pending flush in RUN issues the first sweep write on the same edge it enters FLUSH.
      sweep_wr = (state_q != S_RUN) || flush_q;
      last     = (state_q != S_RUN) && (&cnt_q);
      push     = (state_q == S_RUN) && !flush_q && upd_valid && upd_ready_q;
      pop      = (state_q == S_RUN) && !flush_q && (count_q != '0) && !hazard_stall;

      if (sweep_wr) begin
         we_d       = 1'b1;
         wr_d.idx   = cnt_q;
         wr_d.tag   = '0;
         wr_d.target = '0;
         wr_d.state = 2'b01;
         valid_d    = 1'b0;
         cnt_d      = cnt_q + 1'b1;
         if (state_q == S_RUN) begin
            state_d  = S_FLUSH;
            flush_d  = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
         end else if (last) begin
            state_d      = S_RUN;
            flush_d      = 1'b0;
            flush_done_d = (state_q == S_FLUSH) || flush_q || flush_req;
         end else begin
            flush_d = flush_q || flush_req;
         end
      end else begin
         flush_d = flush_req;
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            we_d     = 1'b1;
            wr_d     = head;
            valid_d  = 1'b1;
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end

      // Ready and busy follow the settled state, so they lag a state change by one cycle.
      upd_ready_d = (state_q == S_RUN) && (state_d == S_RUN) && (count_d < CNT_W'(DEPTH));
      busy_d      = !((state_q == S_RUN) && (state_d == S_RUN));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_INIT;
         cnt_q        <= '0;
         flush_q      <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         upd_ready_q  <= 1'b0;
         flush_done_q <= 1'b0;
         busy_q       <= 1'b1;
         we_q         <= 1'b0;
         wr_q         <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         flush_q      <= flush_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         upd_ready_q  <= upd_ready_d;
         flush_done_q <= flush_done_d;
         busy_q       <= busy_d;
         we_q         <= we_d;
         wr_q         <= wr_d;
         valid_q      <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{idx: upd_pc[IDX_W+1:2], tag: upd_pc[31:IDX_W+2],
                                     target: upd_target, state: upd_state};
   end

   assign upd_ready  = upd_ready_q;
   assign flush_done = flush_done_q;
   assign busy       = busy_q;
   assign bt_we      = we_q;
   assign bt_idx     = wr_q.idx;
   assign bt_tag     = wr_q.tag;
   assign bt_target  = wr_q.target;
   assign bt_state   = wr_q.state;
   assign bt_valid   = valid_q;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench for bp_update_scheduler: stimulus queues expected table writes,
// a negedge monitor pops and compares every bt_we cycle.
module tb_bp_update_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        upd_valid = 1'b0;
   logic        upd_ready;
   logic [31:0] upd_pc = '0;
   logic [31:0] upd_target = '0;
   logic [1:0]  upd_state = '0;
   logic        hazard_stall = 1'b0;
   logic        flush_req = 1'b0;
   logic        flush_done;
   logic        bt_we;
   logic [5:0]  bt_idx;
   logic [23:0] bt_tag;
   logic [31:0] bt_target;
   logic [1:0]  bt_state;
   logic        bt_valid;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [5:0]  idx;
      logic [23:0] tag;
      logic [31:0] tgt;
      logic [1:0]  st;
      logic        v;
      logic        done;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e, mon_g;

   bp_update_scheduler #(.IDX_W(6), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_pc(upd_pc), .upd_target(upd_target), .upd_state(upd_state),
      .hazard_stall(hazard_stall), .flush_req(flush_req), .flush_done(flush_done),
      .bt_we(bt_we), .bt_idx(bt_idx), .bt_tag(bt_tag), .bt_target(bt_target),
      .bt_state(bt_state), .bt_valid(bt_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bt_we) begin
            checks++;
            mon_g = '{idx: bt_idx, tag: bt_tag, tgt: bt_target, st: bt_state,
                      v: bt_valid, done: flush_done};
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write got=%h", mon_g);
            end else begin
               mon_e = sb.pop_front();
               if (mon_g !== mon_e)
                  begin errors++; $display("FAIL table_write got=%h exp=%h", mon_g, mon_e); end
            end
         end else begin
            checks++;
            if (flush_done !== 1'b0)
               begin errors++; $display("FAIL done_without_write got=%b exp=0", flush_done); end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic push_sweep(input bit done_at_end);
      for (int i = 0; i < 64; i++)
         sb.push_back('{idx: 6'(i), tag: '0, tgt: '0, st: 2'b01, v: 1'b0,
                        done: done_at_end && (i == 63)});
   endtask

   // Offers one update and returns just after the accepting edge.
   task automatic push_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] st,
                           input logic [5:0] eidx, input logic [23:0] etag, input bit expect_wr);
      int n;
      upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_state = st;
      n = 0;
      while (!upd_ready && n < 200) begin tick; n++; end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL push_timeout got=ready0 exp=ready1");
      end else begin
         if (expect_wr)
            sb.push_back('{idx: eidx, tag: etag, tgt: tgt, st: st, v: 1'b1, done: 1'b0});
         tick;
      end
      upd_valid = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) tick;
      chk("rst_upd_ready", 32'(upd_ready), 0);
      chk("rst_busy", 32'(busy), 1);
      chk("rst_bt_we", 32'(bt_we), 0);
      chk("rst_bt_idx", 32'(bt_idx), 0);
      chk("rst_bt_state", 32'(bt_state), 0);
      chk("rst_flush_done", 32'(flush_done), 0);

      // init sweep: writes in cycles 1..64, ready/idle from 65
      push_sweep(1'b0);
      rst_n = 1'b1;
      tick;
      chk("init_first_idx", 32'(bt_idx), 0);
      repeat (63) tick;
      chk("init_last_idx", 32'(bt_idx), 63);
      chk("init_ready_lag", 32'(upd_ready), 0);
      chk("init_busy_lag", 32'(busy), 1);
      tick;
      chk("init_ready", 32'(upd_ready), 1);
      chk("init_busy_low", 32'(busy), 0);
      chk("init_sb_empty", sb.size(), 0);

      // single update, two-cycle latency
      push_upd(32'h0000_0104, 32'h0000_0200, 2'b11, 6'h01, 24'h000001, 1'b1);
      chk("lat_no_we_n1", 32'(bt_we), 0);
      tick;
      chk("lat_we_n2", 32'(bt_we), 1);
      tick;

      // fill under stall, fifth offer refused, drain in order (incl. duplicate pc)
      hazard_stall = 1'b1;
      push_upd(32'h0000_00FC, 32'h0000_1000, 2'b00, 6'h3F, 24'h000000, 1'b1);
      push_upd(32'h8000_0040, 32'hDEAD_BEEC, 2'b10, 6'h10, 24'h800000, 1'b1);
      push_upd(32'h1234_5678, 32'h0000_0004, 2'b01, 6'h1E, 24'h123456, 1'b1);
      push_upd(32'h0000_0104, 32'h0000_0300, 2'b00, 6'h01, 24'h000001, 1'b1);
      chk("full_ready_low", 32'(upd_ready), 0);
      upd_valid = 1'b1; upd_pc = 32'h0000_0200;
      repeat (3) begin tick; chk("full_hold", 32'(upd_ready), 0); end
      upd_valid = 1'b0;
      chk("stall_held", sb.size(), 4);
      hazard_stall = 1'b0;
      repeat (6) tick;
      chk("drain_ready", 32'(upd_ready), 1);
      chk("drain_sb_empty", sb.size(), 0);

      // flush discards queued entries and sweeps the table
      hazard_stall = 1'b1;
      push_upd(32'h0000_0400, 32'h0000_0111, 2'b11, 6'h00, 24'h000004, 1'b0);
      push_upd(32'h0000_0404, 32'h0000_0222, 2'b11, 6'h01, 24'h000004, 1'b0);
      push_upd(32'h0000_0408, 32'h0000_0333, 2'b11, 6'h02, 24'h000004, 1'b0);
      push_sweep(1'b1);
      flush_req = 1'b1;
      tick;
      flush_req = 1'b0;
      tick;
      hazard_stall = 1'b0;
      chk("flush_ready_low", 32'(upd_ready), 0);
      chk("flush_busy", 32'(busy), 1);
      chk("flush_first_idx", 32'(bt_idx), 0);
      repeat (63) tick;
      chk("flush_last_ready", 32'(upd_ready), 0);
      chk("flush_done_pulse", 32'(flush_done), 1);
      tick;
      chk("flush_ready_back", 32'(upd_ready), 1);
      chk("flush_busy_low", 32'(busy), 0);
      chk("flush_sb_empty", sb.size(), 0);
      push_upd(32'h0000_0008, 32'h0000_0010, 2'b11, 6'h02, 24'h000000, 1'b1);
      repeat (3) tick;
      chk("post_flush_sb", sb.size(), 0);

      // flush_req during INIT at idx 10 is absorbed into the same sweep
      rst_n = 1'b0;
      sb.delete();
      push_sweep(1'b1);
      tick;
      rst_n = 1'b1;
      repeat (11) tick;
      chk("init_idx10", 32'(bt_idx), 10);
      flush_req = 1'b1;
      tick;
      flush_req = 1'b0;
      repeat (53) tick;
      tick;
      chk("absorb_ready", 32'(upd_ready), 1);
      chk("absorb_sb_empty", sb.size(), 0);
      repeat (4) tick;
      chk("absorb_no_resweep", 32'(busy), 0);

      // reset mid-queue
      hazard_stall = 1'b1;
      push_upd(32'h0000_0500, 32'h0000_0AAA, 2'b10, 6'h00, 24'h000005, 1'b0);
      push_upd(32'h0000_0504, 32'h0000_0BBB, 2'b10, 6'h01, 24'h000005, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(upd_ready), 0);
      chk("mid_rst_busy", 32'(busy), 1);
      chk("mid_rst_we", 32'(bt_we), 0);
      chk("mid_rst_idx", 32'(bt_idx), 0);
      chk("mid_rst_target", bt_target, 0);
      chk("mid_rst_valid", 32'(bt_valid), 0);
      sb.delete();
      push_sweep(1'b0);
      hazard_stall = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      chk("restart_idx0", 32'(bt_idx), 0);
      repeat (63) tick;
      chk("restart_ready_lag", 32'(upd_ready), 0);
      tick;
      chk("restart_ready", 32'(upd_ready), 1);
      push_upd(32'h1234_5678, 32'h0000_0040, 2'b10, 6'h1E, 24'h123456, 1'b1);
      repeat (4) tick;
      chk("final_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
